cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter RAM_ADDRESS_WIDTH, default 16, byte-address width (A[15:8] tag, A[7:4] index, A[3:2] block offset, A[1:0] byte offset).
REQ-002 Parameter DATA_WIDTH, default 32, main-memory word width.
REQ-003 Parameter CACHE_ADDRESS_WIDTH, default 4, cache index width.
REQ-004 Parameter WORDS_PER_LINE, default 4, words fetched per refill; fixed at 4 in this revision.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 miss_valid  in  1  cache reports a read miss.
REQ-009 miss_addr  in  RAM_ADDRESS_WIDTH  missing byte address.
REQ-010 miss_ready  out  1  controller can accept a miss (high only in IDLE).
REQ-011 mem_req  out  1  word read request to main memory.
REQ-012 mem_addr  out  RAM_ADDRESS_WIDTH  word-aligned byte address of the request.
REQ-013 mem_rvalid  in  1  main memory returns mem_rdata this cycle.
REQ-014 mem_rdata  in  DATA_WIDTH  returned word.
REQ-015 crit_valid  out  1  one-cycle pulse: requested word available.
REQ-016 crit_data  out  DATA_WIDTH  requested word.
REQ-017 line_valid  out  1  one-cycle pulse: full line ready for cache write.
REQ-018 line_data  out  4*DATA_WIDTH  word k at bits [32k+31:32k].
REQ-019 line_tag  out  8  tag of the filled line.
REQ-020 line_index  out  CACHE_ADDRESS_WIDTH  cache set to write.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 States IDLE, REQ, WAIT, DONE; encoding in shared package.
REQ-023 IDLE: miss_valid && miss_ready captures miss_addr, sets word counter and critical offset to miss_addr[3:2], next state REQ.
REQ-024 Critical-word-first: fetch order is offset c, c+1, c+2, c+3 modulo 4 (wrap-around: c=2 gives 2,3,0,1).
REQ-025 REQ: mem_req=1 for exactly one cycle, mem_addr={addr[15:4], cnt, 2'b00}; next state WAIT.
REQ-026 WAIT: mem_req=0; on mem_rvalid store mem_rdata into line word cnt; if fourth word go DONE, else cnt+1 (mod 4), go REQ.
REQ-027 Only one memory request outstanding; mem_rvalid in IDLE, REQ or DONE is ignored.
REQ-028 crit_valid pulses in the cycle after the first mem_rvalid of a refill, crit_data = that word.
REQ-029 DONE: line_valid=1 for one cycle with registered line_data, line_tag=addr[15:8], line_index=addr[7:4]; next state IDLE.
REQ-030 miss_valid during busy is not accepted; upstream holds it until miss_ready.
REQ-031 Latency with zero-wait memory (mem_rvalid the cycle after mem_req): accept to line_valid = 9 cycles.
REQ-032 miss_addr[1:0] ignored; all fetches word-aligned.
REQ-033 line_data, line_tag, line_index, crit_data hold their last values between pulses.

Reset
REQ-034 rst asserted asynchronously forces IDLE; miss_ready=1, mem_req=0, crit_valid=0, line_valid=0, busy=0, line_data=0, crit_data=0, line_tag=0, line_index=0, counter=0.
REQ-035 Reset mid-refill abandons the refill; no line_valid is produced for it, a late mem_rvalid after deassertion is ignored.

Structure
REQ-036 Shared package holds state enum, address-field widths/positions (tag, index, offset) and WORDS_PER_LINE.
REQ-037 One natural sub-module: refill_line_buf (4-word register file, write by offset, parallel 128-bit read).

Verification
REQ-038 Miss 0x1234, memory returns 0xA0..0xA3 for offsets 1,2,3,0 -> mem_addr 0x1234,0x1238,0x123C,0x1230; line_data={A0..A3 per offset}, line_tag 0x12, line_index 3.
REQ-039 Miss 0x00F8 (offset 2) -> order 0x00F8,0x00FC,0x00F0,0x00F4; crit_data = word from 0x00F8.
REQ-040 Zero-wait memory, miss 0x0000 -> line_valid exactly 9 cycles after accept; crit_valid 3 cycles after accept.
REQ-041 miss_valid pulsed while busy -> miss_ready=0, no second capture, only one line_valid.
REQ-042 rst asserted after second mem_rvalid -> all outputs reset values immediately, no line_valid; next miss 0x4440 completes normally.
REQ-043 Spurious mem_rvalid in IDLE -> no state change, no pulses.

Source files
------------

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller.
// Holds the refill FSM state encoding, the byte-address field layout
// (tag / index / word offset / byte offset) and the line geometry.
package cache_refill_ctrl_pkg;

    // Line geometry: four words per line, selected by a 2-bit word offset.
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_SEL_W     = 2;

    // Byte-address field positions: A[15:8] tag, A[7:4] index, A[3:2] word, A[1:0] byte.
    localparam int unsigned BYTE_OFF_LSB   = 0;
    localparam int unsigned BYTE_OFF_W     = 2;
    localparam int unsigned WORD_OFF_LSB   = 2;
    localparam int unsigned INDEX_LSB      = 4;
    localparam int unsigned TAG_LSB        = 8;
    localparam int unsigned TAG_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/refill_line_buf.sv
// Four-word refill line buffer.
// Ports: clk/rst (async active-high), wr_en/wr_idx/wr_data write one word by
// offset; rd_data_c is the parallel read of the whole line including the word
// being written this cycle, so the last word of a refill can be captured on
// the same edge it arrives.
module refill_line_buf
    import cache_refill_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [WORD_SEL_W-1:0]                wr_idx,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] rd_data_c
);

    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] words_q, words_d;

    // Write-by-offset merge.
    always_comb begin
        words_d = words_q;
        if (wr_en) begin
            words_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    // Word k lands on bits [k*DATA_WIDTH +: DATA_WIDTH].
    assign rd_data_c = words_d;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Critical-word-first cache line refill controller.
// Accepts a read miss (miss_valid/miss_ready), fetches the four words of the
// line one at a time starting at the missing word and wrapping (mem_req /
// mem_addr / mem_rvalid / mem_rdata, one request outstanding), pulses
// crit_valid/crit_data with the first returned word, then pulses line_valid
// with line_data/line_tag/line_index for the cache write. busy is high
// whenever not idle. Clock clk, asynchronous active-high reset rst.
module cache_refill_ctrl #(
    parameter int unsigned RAM_ADDRESS_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned CACHE_ADDRESS_WIDTH = 4,
    parameter int unsigned WORDS_PER_LINE      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 miss_valid,
    input  logic [RAM_ADDRESS_WIDTH-1:0]         miss_addr,
    output logic                                 miss_ready,
    output logic                                 mem_req,
    output logic [RAM_ADDRESS_WIDTH-1:0]         mem_addr,
    input  logic                                 mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic                                 crit_valid,
    output logic [DATA_WIDTH-1:0]                crit_data,
    output logic                                 line_valid,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_data,
    output logic [7:0]                           line_tag,
    output logic [CACHE_ADDRESS_WIDTH-1:0]       line_index,
    output logic                                 busy
);

    localparam int unsigned LINE_W   = WORDS_PER_LINE * DATA_WIDTH;
    localparam int unsigned SEL_W    = cache_refill_ctrl_pkg::WORD_SEL_W;
    localparam int unsigned IDX_LSB  = cache_refill_ctrl_pkg::INDEX_LSB;
    localparam int unsigned LADDR_W  = RAM_ADDRESS_WIDTH - IDX_LSB;
    localparam int unsigned TAG_OFF  = cache_refill_ctrl_pkg::TAG_LSB - IDX_LSB;
    localparam int unsigned TAG_W    = cache_refill_ctrl_pkg::TAG_W;
    localparam int unsigned BOFF_W   = cache_refill_ctrl_pkg::BYTE_OFF_W;
    localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(WORDS_PER_LINE - 1);

    cache_refill_ctrl_pkg::refill_state_e state_q, state_d;

    logic [LADDR_W-1:0]             line_addr_q, line_addr_d;   // A[15:4] of the miss
    logic [SEL_W-1:0]               cnt_q, cnt_d;               // word offset being fetched
    logic [SEL_W-1:0]               nrecv_q, nrecv_d;           // words already returned
    logic                           miss_ready_q, miss_ready_d;
    logic                           busy_q, busy_d;
    logic                           mem_req_q, mem_req_d;
    logic [RAM_ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                           crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0]          crit_data_q, crit_data_d;
    logic                           line_valid_q, line_valid_d;
    logic [LINE_W-1:0]              line_data_q, line_data_d;
    logic [TAG_W-1:0]               line_tag_q, line_tag_d;
    logic [CACHE_ADDRESS_WIDTH-1:0] line_index_q, line_index_d;

    logic                           buf_wr_c;
    logic [LINE_W-1:0]              buf_line_c;

    // Byte offset never matters: every fetch is word-aligned.
    logic unused_byte_off;
    assign unused_byte_off = ^miss_addr[cache_refill_ctrl_pkg::BYTE_OFF_LSB +: BOFF_W];

    // Only a return in WAIT belongs to the outstanding request.
    assign buf_wr_c = (state_q == cache_refill_ctrl_pkg::ST_WAIT) && mem_rvalid;

    refill_line_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr_c),
        .wr_idx    (cnt_q),
        .wr_data   (mem_rdata),
        .rd_data_c (buf_line_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        cnt_d        = cnt_q;
        nrecv_d      = nrecv_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        line_valid_d = 1'b0;
        line_data_d  = line_data_q;
        line_tag_d   = line_tag_q;
        line_index_d = line_index_q;

        case (state_q)
            cache_refill_ctrl_pkg::ST_IDLE: begin
                if (miss_valid && miss_ready_q) begin
                    line_addr_d = miss_addr[RAM_ADDRESS_WIDTH-1:IDX_LSB];
                    cnt_d       = miss_addr[cache_refill_ctrl_pkg::WORD_OFF_LSB +: SEL_W];
                    nrecv_d     = '0;
                    state_d     = cache_refill_ctrl_pkg::ST_REQ;
                end
            end
            cache_refill_ctrl_pkg::ST_REQ: begin
                state_d = cache_refill_ctrl_pkg::ST_WAIT;
            end
            cache_refill_ctrl_pkg::ST_WAIT: begin
                if (mem_rvalid) begin
                    if (nrecv_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = mem_rdata;
                    end
                    if (nrecv_q == LAST_WORD) begin
                        line_valid_d = 1'b1;
                        line_data_d  = buf_line_c;
                        line_tag_d   = line_addr_q[TAG_OFF +: TAG_W];
                        line_index_d = line_addr_q[0 +: CACHE_ADDRESS_WIDTH];
                        state_d      = cache_refill_ctrl_pkg::ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + SEL_W'(1);
                        nrecv_d = nrecv_q + SEL_W'(1);
                        state_d = cache_refill_ctrl_pkg::ST_REQ;
                    end
                end
            end
            cache_refill_ctrl_pkg::ST_DONE: begin
                state_d = cache_refill_ctrl_pkg::ST_IDLE;
            end
            default: begin
                state_d = cache_refill_ctrl_pkg::ST_IDLE;
            end
        endcase

        // Outputs registered from the upcoming state so they align with it.
        miss_ready_d = (state_d == cache_refill_ctrl_pkg::ST_IDLE);
        busy_d       = !miss_ready_d;
        mem_req_d    = (state_d == cache_refill_ctrl_pkg::ST_REQ);
        mem_addr_d   = mem_req_d ? {line_addr_d, cnt_d, {BOFF_W{1'b0}}} : mem_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= cache_refill_ctrl_pkg::ST_IDLE;
            line_addr_q  <= '0;
            cnt_q        <= '0;
            nrecv_q      <= '0;
            miss_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            line_valid_q <= 1'b0;
            line_data_q  <= '0;
            line_tag_q   <= '0;
            line_index_q <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            cnt_q        <= cnt_d;
            nrecv_q      <= nrecv_d;
            miss_ready_q <= miss_ready_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            line_valid_q <= line_valid_d;
            line_data_q  <= line_data_d;
            line_tag_q   <= line_tag_d;
            line_index_q <= line_index_d;
        end
    end

    assign miss_ready = miss_ready_q;
    assign busy       = busy_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign line_valid = line_valid_q;
    assign line_data  = line_data_q;
    assign line_tag   = line_tag_q;
    assign line_index = line_index_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Testbench for cache_refill_ctrl: a behavioural memory that answers each
// request after a random delay, and a reference model that derives the fetch
// order, critical word, line contents and latencies from the miss address.
module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst;
    logic         miss_valid;
    logic [15:0]  miss_addr;
    logic         miss_ready;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_valid;
    logic [127:0] line_data;
    logic [7:0]   line_tag;
    logic [3:0]   line_index;
    logic         busy;

    int npass = 0;
    int nchk  = 0;

    logic [31:0]  mem_word [4];   // memory contents of the line, indexed by word offset
    logic [127:0] last_line;

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .line_valid (line_valid),
        .line_data  (line_data),
        .line_tag   (line_tag),
        .line_index (line_index),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_miss_ready"}, miss_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_crit_valid"}, crit_valid, 0);
        chk({tag, "_line_valid"}, line_valid, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_idle(tag);
        chk({tag, "_line_data"}, line_data, 0);
        chk({tag, "_crit_data"}, crit_data, 0);
        chk({tag, "_line_tag"}, line_tag, 0);
        chk({tag, "_line_index"}, line_index, 0);
    endtask

    task automatic fill_random_words;
        for (int k = 0; k < 4; k++) mem_word[k] = $urandom;
    endtask

    // One refill. abort_n > 0 asserts rst just after the abort_n-th data return.
    task automatic run_miss(input logic [15:0] addr, input int max_dly, input bit zero_wait,
                            input bit poke, input int abort_n);
        int c, cyc, nreq, nrv, ncrit, nline, dly, first_rv, crit_cyc;
        bit pend, done, abort_now;
        logic [127:0] exp_line;
        logic [15:0]  exp_a;

        c = int'(addr[3:2]);
        for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = mem_word[k];

        for (int i = 0; i < 20 && !miss_ready; i++) tick;
        chk("ready_before_miss", miss_ready, 1);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick;
        miss_valid = 1'b0;
        miss_addr  = 16'($urandom);

        cyc = 1; nreq = 0; nrv = 0; ncrit = 0; nline = 0; dly = 0;
        first_rv = -100; crit_cyc = -1; pend = 0; done = 0; abort_now = 0;
        while (!done && cyc < 200) begin
            chk("busy_in_refill", busy, 1);
            chk("ready_in_refill", miss_ready, 0);
            if (mem_req) begin
                chk("one_outstanding", pend, 0);
                exp_a = {addr[15:4], 4'(((c + nreq) % 4) * 4)};
                chk("mem_addr", mem_addr, exp_a);
                nreq++;
            end
            if (crit_valid) begin
                ncrit++;
                crit_cyc = cyc;
                chk("crit_cycle", cyc, first_rv + 1);
                chk("crit_data", crit_data, mem_word[c]);
            end
            if (line_valid) begin
                nline++;
                chk("line_data", line_data, exp_line);
                chk("line_tag", line_tag, addr[15:8]);
                chk("line_index", line_index, addr[7:4]);
                if (zero_wait) begin
                    chk("latency_line", cyc, 9);
                    chk("latency_crit", crit_cyc, 3);
                end
                last_line = exp_line;
                done = 1;
            end

            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pend && dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word[(c + nrv) % 4];
                if (nrv == 0) first_rv = cyc;
                nrv++;
                pend = 0;
                abort_now = (abort_n > 0) && (nrv == abort_n);
            end else if (pend) begin
                dly--;
            end
            if (mem_req) begin
                pend = 1;
                dly  = (max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0;
            end
            if (poke && !line_valid) begin
                miss_valid = 1'($urandom_range(1, 0));
                miss_addr  = 16'($urandom);
            end else begin
                miss_valid = 1'b0;
            end

            tick;
            cyc++;
            if (abort_now) begin
                mem_rvalid = 1'b0;
                miss_valid = 1'b0;
                #2 rst = 1'b1;
                #1 chk_reset_vals("abort");
                last_line = '0;
                return;
            end
        end
        mem_rvalid = 1'b0;
        miss_valid = 1'b0;
        if (!done) chk("refill_timeout", 0, 1);
        chk("num_requests", nreq, 4);
        chk("num_crit", ncrit, 1);
        chk("num_line", nline, 1);
        chk_idle("post_line");
        chk("line_hold", line_data, exp_line);
        chk("crit_hold", crit_data, mem_word[c]);
    endtask

    initial begin
        int md;
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        last_line  = '0;
        #1 chk_reset_vals("reset");
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk_idle("after_reset");

        // Miss 0x1234: words A0..A3 returned for offsets 1,2,3,0.
        mem_word[1] = 32'hA0; mem_word[2] = 32'hA1; mem_word[3] = 32'hA2; mem_word[0] = 32'hA3;
        run_miss(16'h1234, 2, 1'b0, 1'b0, 0);
        chk("fixed_1234_line", line_data, 128'h000000A2_000000A1_000000A0_000000A3);
        chk("fixed_1234_tag", line_tag, 8'h12);
        chk("fixed_1234_index", line_index, 4'h3);

        // Wrap-around order starting at offset 2.
        fill_random_words();
        run_miss(16'h00F8, 1, 1'b0, 1'b0, 0);
        chk("wrap_00f8_crit", crit_data, mem_word[2]);

        // Zero-wait memory latency.
        fill_random_words();
        run_miss(16'h0000, 0, 1'b1, 1'b0, 0);

        // Misses presented while busy must be ignored.
        fill_random_words();
        run_miss(16'hBEEF, 3, 1'b0, 1'b1, 0);

        // Spurious returns while idle.
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            tick;
            chk_idle("spurious");
            chk("spurious_line_hold", line_data, last_line);
        end
        mem_rvalid = 1'b0;

        // Reset after the second return abandons the refill.
        fill_random_words();
        run_miss(16'h5678, 2, 1'b0, 1'b0, 2);
        #3 rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        tick;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_idle("post_abort");
            tick;
        end
        chk("post_abort_line_data", line_data, 0);
        fill_random_words();
        run_miss(16'h4440, 0, 1'b1, 1'b0, 0);

        // Random misses, delays and busy-time pokes.
        for (int n = 0; n < 20; n++) begin
            fill_random_words();
            md = int'($urandom_range(3, 0));
            run_miss(16'($urandom), md, md == 0, 1'($urandom_range(1, 0)), 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
